alarm_controller: RTL and testbench

- Sequences the clock's alarm output. Compares the running time with the user-set alarm time and drives the one-bit alarm_trigger that feeds the alarm signal driver.
- Handles ring timeout, snooze with a bounded snooze count, and stop.
- Sits between the timekeeping counters, the button debouncers, and the alarm signal output stage.

---
 rtl/alarm_controller.sv | 158 +++++++++++++++
 tb/tb_alarm_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm sequencer: arm, ring with timeout, bounded snooze and stop.
// Define ALARM_BLINK_EN to pulse alarm_trigger 1 s on / 1 s off while ringing.
module alarm_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  input  logic       snooze_req,
  input  logic       stop_req,
  output logic       alarm_trigger,
  output logic       ringing,
  output logic       snoozed,
  output logic [1:0] snooze_count
);

  localparam int RW = $clog2(RING_SECONDS) + 1;
  localparam int SW = $clog2(SNOOZE_SECONDS) + 1;

  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECONDS - 1);
  localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING,
    SNOOZED
  } state_t;

  state_t state;
  state_t state_nx;
  state_t exit_st;

  logic [RW-1:0] ring_cnt;
  logic [RW-1:0] ring_cnt_nx;
  logic [SW-1:0] snz_cnt;
  logic [SW-1:0] snz_cnt_nx;
  logic [1:0]    snz_used;
  logic [1:0]    snz_used_nx;

  logic match;
  logic quit;
  logic ring_done;
  logic snz_done;

  assign match = tick_1hz & alarm_en
               & (cur_hour == alarm_hour)
               & (cur_min == alarm_min)
               & (cur_sec == 6'd0);

  // Every way out of an event lands here; en=0 always ends in IDLE.
  assign exit_st   = alarm_en ? ARMED : IDLE;
  assign quit      = stop_req | ~alarm_en;
  assign ring_done = tick_1hz & (ring_cnt >= RING_LAST);
  assign snz_done  = tick_1hz & (snz_cnt >= SNZ_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      snz_used <= '0;
    end else begin
      state    <= state_nx;
      ring_cnt <= ring_cnt_nx;
      snz_cnt  <= snz_cnt_nx;
      snz_used <= snz_used_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ring_cnt_nx = ring_cnt;
    snz_cnt_nx  = snz_cnt;
    snz_used_nx = snz_used;
    unique case (state)
      IDLE: begin
        if (alarm_en) state_nx = ARMED;
      end
      ARMED: begin
        if (!alarm_en) begin
          state_nx = IDLE;
        end else if (match) begin
          state_nx    = RINGING;
          ring_cnt_nx = '0;
          snz_used_nx = '0;
        end
      end
      RINGING: begin
        // Buttons outrank the tick, so a pressed cycle never counts.
        if (quit) begin
          state_nx = exit_st;
        end else if (snooze_req) begin
          if (snz_used < SNZ_MAX) begin
            state_nx    = SNOOZED;
            snz_used_nx = snz_used + 2'd1;
            snz_cnt_nx  = '0;
          end else begin
            state_nx = exit_st;
          end
        end else if (ring_done) begin
          state_nx = exit_st;
        end else if (tick_1hz) begin
          ring_cnt_nx = ring_cnt + RW'(1);
        end
      end
      SNOOZED: begin
        if (quit) begin
          state_nx = exit_st;
        end else if (snz_done) begin
          state_nx    = RINGING;
          ring_cnt_nx = '0;
        end else if (tick_1hz) begin
          snz_cnt_nx = snz_cnt + SW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ringing      = (state == RINGING);
  assign snoozed      = (state == SNOOZED);
  assign snooze_count = snz_used;

`ifdef ALARM_BLINK_EN
  logic blink;
  logic blink_nx;

  always_ff @(posedge clk) begin
    if (rst) blink <= 1'b0;
    else     blink <= blink_nx;
  end

  always_comb begin
    blink_nx = blink;
    if (state_nx == RINGING && state != RINGING) begin
      blink_nx = 1'b1;
    end else if (state == RINGING && state_nx == RINGING
                 && tick_1hz) begin
      blink_nx = ~blink;
    end
  end

  assign alarm_trigger = ringing & blink;
`else
  assign alarm_trigger = ringing;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios then random traffic,
// all checked against a countdown-based model of the alarm event.
module tb_alarm_controller;

  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;
`ifdef ALARM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       snooze_req;
  logic       stop_req;
  logic       alarm_trigger;
  logic       ringing;
  logic       snoozed;
  logic [1:0] snooze_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_controller #(
    .RING_SECONDS  (RING),
    .SNOOZE_SECONDS(SNZ),
    .MAX_SNOOZE    (MAXS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .cur_hour     (cur_hour),
    .cur_min      (cur_min),
    .cur_sec      (cur_sec),
    .alarm_hour   (alarm_hour),
    .alarm_min    (alarm_min),
    .alarm_en     (alarm_en),
    .snooze_req   (snooze_req),
    .stop_req     (stop_req),
    .alarm_trigger(alarm_trigger),
    .ringing      (ringing),
    .snoozed      (snoozed),
    .snooze_count (snooze_count)
  );

  typedef enum int {M_IDLE, M_ARMED, M_RING, M_SNZ} mode_t;
  mode_t m_mode;
  int    m_ring_left;
  int    m_snz_left;
  int    m_used;
  int    th, tm, ts;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic void m_exit();
    m_mode = alarm_en ? M_ARMED : M_IDLE;
  endfunction

  function automatic void model_step();
    bit m;
    if (rst) begin
      m_mode = M_IDLE;
      m_used = 0;
      return;
    end
    m = tick_1hz && alarm_en && cur_hour == alarm_hour
        && cur_min == alarm_min && cur_sec == 0;
    case (m_mode)
      M_IDLE: if (alarm_en) m_mode = M_ARMED;
      M_ARMED: begin
        if (!alarm_en) m_mode = M_IDLE;
        else if (m) begin
          m_mode = M_RING;
          m_ring_left = RING;
          m_used = 0;
        end
      end
      M_RING: begin
        if (stop_req || !alarm_en) m_exit();
        else if (snooze_req && m_used >= MAXS) m_exit();
        else if (snooze_req) begin
          m_used++;
          m_mode = M_SNZ;
          m_snz_left = SNZ;
        end else if (tick_1hz) begin
          m_ring_left--;
          if (m_ring_left == 0) m_exit();
        end
      end
      M_SNZ: begin
        if (stop_req || !alarm_en) m_exit();
        else if (tick_1hz) begin
          m_snz_left--;
          if (m_snz_left == 0) begin
            m_mode = M_RING;
            m_ring_left = RING;
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endfunction

  function automatic logic [4:0] model_out();
    logic trig;
    trig = (m_mode == M_RING);
    if (BLINK && ((RING - m_ring_left) % 2) != 0) trig = 1'b0;
    return {trig, m_mode == M_RING, m_mode == M_SNZ, 2'(m_used)};
  endfunction

  task automatic cyc(string tag);
    @(posedge clk);
    model_step();
    #1;
    chk(tag, 32'({alarm_trigger, ringing, snoozed, snooze_count}),
        32'(model_out()));
    tick_1hz   = 1'b0;
    snooze_req = 1'b0;
    stop_req   = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic show_time();
    cur_hour = 5'(th);
    cur_min  = 6'(tm);
    cur_sec  = 6'(ts);
  endtask

  task automatic set_time(int h, int m, int s);
    th = h; tm = m; ts = s;
    show_time();
  endtask

  task automatic tick(string tag);
    ts++;
    if (ts == 60) begin ts = 0; tm++; end
    if (tm == 60) begin tm = 0; th++; end
    if (th == 24) th = 0;
    show_time();
    tick_1hz = 1'b1;
    cyc(tag);
  endtask

  task automatic ring_now(string tag);
    set_time(7, 29, 59);
    tick(tag);
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b0;
    snooze_req = 1'b0; stop_req = 1'b0;
    alarm_hour = 5'd7; alarm_min = 6'd30;
    m_mode = M_IDLE; m_used = 0;
    m_ring_left = RING; m_snz_left = SNZ;
    set_time(0, 0, 0);

    rst = 1'b1; cyc("reset");
    rst = 1'b1; cyc("reset");
    chk("reset_out", 32'({alarm_trigger, ringing, snoozed,
        snooze_count}), 32'd0);
    alarm_en = 1'b1; cyc("arm");

    set_time(7, 30, 4);
    tick("nz_sec");
    chk("nz_sec_trig", 32'(alarm_trigger), 32'd0);
    set_time(7, 29, 58);
    tick("pre");
    tick("match");
    chk("ring_rise", 32'(alarm_trigger), 32'd1);

    repeat (RING - 1) tick("ringing");
    chk("ring_59", 32'(ringing), 32'd1);
    tick("timeout");
    chk("timeout_trig", 32'(alarm_trigger), 32'd0);
    chk("timeout_ring", 32'(ringing), 32'd0);

    ring_now("ring2");
    snooze_req = 1'b1; cyc("snooze1");
    chk("snz1", 32'({alarm_trigger, snoozed, snooze_count}),
        32'({1'b0, 1'b1, 2'd1}));
    repeat (SNZ - 1) tick("snoozing");
    chk("snz_299", 32'(snoozed), 32'd1);
    tick("resume");
    chk("resume_ring", 32'(ringing), 32'd1);

    for (int i = 0; i < 2; i++) begin
      snooze_req = 1'b1; cyc("snooze_n");
      repeat (SNZ) tick("snoozing");
    end
    snooze_req = 1'b1; cyc("snooze4");
    chk("limit", 32'({ringing, snoozed, snooze_count}),
        32'({1'b0, 1'b0, 2'd3}));

    ring_now("ring3");
    chk("cnt_clear", 32'(snooze_count), 32'd0);
    snooze_req = 1'b1; cyc("snooze");
    repeat (SNZ) tick("snoozing");
    stop_req = 1'b1; snooze_req = 1'b1; cyc("stop_snz");
    chk("stop_wins", 32'({ringing, snoozed, snooze_count}),
        32'({1'b0, 1'b0, 2'd1}));

    ring_now("ring4");
    snooze_req = 1'b1; cyc("snooze");
    alarm_en = 1'b0; cyc("disable");
    chk("disable_out", 32'({alarm_trigger, ringing, snoozed}),
        32'd0);
    alarm_en = 1'b1; cyc("rearm");

    ring_now("ring5");
    rst = 1'b1; cyc("rst_mid");
    chk("rst_mid_out", 32'({alarm_trigger, ringing, snooze_count}),
        32'd0);
    cyc("rearm");

    ring_now("ring6");
    for (int k = 0; k < 4; k++) begin
      chk("blink", 32'(alarm_trigger),
          32'(BLINK ? (k % 2 == 0) : 1'b1));
      if (k < 3) tick("blink_tick");
    end
    stop_req = 1'b1; cyc("stop");

    for (int n = 0; n < 20000; n++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 5) alarm_en = ~alarm_en;
      if ($urandom_range(0, 999) < 20) snooze_req = 1'b1;
      if ($urandom_range(0, 999) < 4) stop_req = 1'b1;
      if ($urandom_range(0, 999) < 1) rst = 1'b1;
      if ($urandom_range(0, 999) < 2) begin
        alarm_hour = 5'($urandom_range(0, 23));
        alarm_min  = 6'($urandom_range(0, 59));
      end
      if ($urandom_range(0, 99) < 60) begin
        r = int'($urandom_range(0, 99));
        if (r < 4) set_time(int'(alarm_hour), int'(alarm_min), 59);
        else if (r < 6)
          set_time(int'(alarm_hour), int'(alarm_min),
                   int'($urandom_range(0, 58)));
        tick("rand");
      end else begin
        cyc("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
